matmul_feeder: RTL
==================

MATMUL_FEEDER -- requirements
Module: matmul_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, element width; matrix size fixed 4x4.
REQ-002 SHALL have ports: clk input 1 clock; rst input 1 reset; one clock, reset synchronous, active-high.
REQ-003 SHALL have: load_valid input 1, row-load request; load_ready output 1, row accepted when both high at posedge.
REQ-004 SHALL have: load_sel input 1 (0=A, 1=B); load_row input 2 row index; load_data input 4*DATA_W, column 0 in MSBs.
REQ-005 SHALL have: go input 1, start request; busy output 1; done output 1, one-cycle completion pulse; go_err output 1, one-cycle pulse.
REQ-006 SHALL have: input_start output 1; counter output 4; inA_flat output 4*DATA_W; inB_flat output 4*DATA_W, lane 0 in MSBs. These drive the systolic matmul array directly.

Function
REQ-007 SHALL store A and B (16 elements each) in internal registers, plus an 8-bit row-loaded mask (4 rows A, 4 rows B).
REQ-008 SHALL drive load_ready=1 only in IDLE; an accepted load writes the row and sets its mask bit; reloading a row overwrites it.
REQ-009 SHALL use FSM states IDLE, START, STREAM, FLUSH.
REQ-010 IDLE: busy=0, counter=0, input_start=0, data outputs 0. go with all mask bits set -> START. go with any mask bit clear -> go_err pulse next cycle, stay IDLE.
REQ-011 go and load accepted in the same cycle: go SHALL evaluate the mask before the update.
REQ-012 START SHALL last exactly 2 cycles with input_start=1, counter=0, data 0, busy=1; then STREAM.
REQ-013 STREAM SHALL run counter 1..7, one value per cycle; counter and data outputs SHALL be registered together, so outputs reflect beat c while counter==c.
REQ-014 Beat c, lane i: k = 4 - c + i; if 0<=k<=3, inA lane i = A[i][k] and inB lane i = B[k][i]; otherwise the lane SHALL be 0.
REQ-015 FLUSH SHALL run counter 8..15 with zero data; on the cycle after counter=15, done=1 for one cycle, counter=0, state IDLE.
REQ-016 go SHALL be ignored when not in IDLE; load_valid SHALL be ignored (not accepted) when not in IDLE.
REQ-017 Matrices and mask SHALL persist after done; go again without reload SHALL replay the identical sequence.
REQ-018 Total latency SHALL be 17 cycles from go accepted to done: 2 START, 7 STREAM, 8 FLUSH.

Reset
REQ-019 rst SHALL force IDLE, clear the mask, and zero counter, input_start, inA_flat, inB_flat, busy, done and go_err on the next posedge.
REQ-020 rst mid-STREAM SHALL abort the run with no done pulse; matrix contents are don't-care after reset.
REQ-021 rst SHALL take priority over go and load in the same cycle.

Structure
REQ-022 A shared package matmul_pkg SHALL hold DATA_W default, N=4, state encoding, and the beat constants STREAM_LAST=7 and FLUSH_LAST=15.
REQ-023 The per-beat skew select SHALL live in one combinational sub-module, skew_select (inputs: beat, matrices; outputs: two flat lanes); FSM and storage stay in matmul_feeder.

Verification
REQ-024 Load A=1..16 row-major and B={2,7,0,0 / 0,2,0,8 / 4,0,2,0 / 0,0,0,1}, then go. Required:
- counter=1: inA={4,0,0,0}, inB={0,0,0,0}.
- counter=4: inA={1,6,11,16}, inB={2,2,2,1}.
- counter=7: inA={0,0,0,13}, inB={0,0,0,0}.
REQ-025 Integration: feeder driving matmul -> first result row [14,11,6,20]; done asserted 17 cycles after go.
REQ-026 go with only 7 rows loaded -> go_err pulse, busy stays 0, outputs stay 0; load 8th row, then go -> normal run.
REQ-027 Load attempt and go while busy -> load_ready=0, stored matrix unchanged, no second run; second go after done replays identical beats.
REQ-028 rst at counter=5 -> next cycle all outputs 0, IDLE, mask clear; go without reload -> go_err.
REQ-029 Simultaneous go and final-row load in IDLE -> go_err, row stored; go next cycle starts a run.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and helpers for the 4x4 matmul feeder.
package matmul_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int N              = 4;
    localparam int CNT_W          = 4;

    // Last counter value of the data-carrying beats and of the zero-data tail.
    localparam logic [CNT_W-1:0] STREAM_LAST = 4'd7;
    localparam logic [CNT_W-1:0] FLUSH_LAST  = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_e;

    // Row-loaded mask layout: bits 3:0 are rows of A, bits 7:4 are rows of B.
    function automatic logic [2:0] mask_idx(input logic sel, input logic [1:0] row);
        return {sel, row};
    endfunction

endpackage

// File: rtl/matmul_feeder_if.sv
// Row-load, control and array-feed bundle between a host and the feeder.
interface matmul_feeder_if #(
    parameter int DATA_W = 32
);
    logic                  load_valid;
    logic                  load_ready;
    logic                  load_sel;
    logic [1:0]            load_row;
    logic [4*DATA_W-1:0]   load_data;
    logic                  go;
    logic                  busy;
    logic                  done;
    logic                  go_err;
    logic                  input_start;
    logic [3:0]            counter;
    logic [4*DATA_W-1:0]   inA_flat;
    logic [4*DATA_W-1:0]   inB_flat;

    // Host side: loads rows, issues go, observes status and the array feed.
    modport master (
        output load_valid, load_sel, load_row, load_data, go,
        input  load_ready, busy, done, go_err, input_start, counter, inA_flat, inB_flat
    );

    // Feeder side.
    modport slave (
        input  load_valid, load_sel, load_row, load_data, go,
        output load_ready, busy, done, go_err, input_start, counter, inA_flat, inB_flat
    );
endinterface

// File: rtl/matmul_feeder_skew_select.sv
// Per-beat diagonal skew: picks which A/B element each lane carries on a beat.
module skew_select
    import matmul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [CNT_W-1:0]                  beat_i,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]   mat_a_i,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]   mat_b_i,
    output logic [N*DATA_W-1:0]               lane_a_o,
    output logic [N*DATA_W-1:0]               lane_b_o
);

    // Lane i on beat c carries A[i][k] and B[k][i] with k = N - c + i, zero when k is out of range.
    always_comb begin
        int k;
        // NOTE: every output gets a default before the loop so no path leaves a latch behind.
        lane_a_o = '0;
        lane_b_o = '0;
        k        = 0;
        for (int i = 0; i < N; i++) begin
            k = N - int'(beat_i) + i;
            if (k >= 0 && k < N) begin
                lane_a_o[(N-1-i)*DATA_W +: DATA_W] = mat_a_i[i][k[1:0]];
                lane_b_o[(N-1-i)*DATA_W +: DATA_W] = mat_b_i[k[1:0]][i];
            end
        end
    end

endmodule

// File: rtl/matmul_feeder.sv
// Stores A and B row by row, then streams them skewed into a 4x4 systolic array.
module matmul_feeder
    import matmul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    matmul_feeder_if.slave  bus
);

    state_e                              state_q;
    logic [CNT_W-1:0]                    counter_q;
    logic                                start_cnt_q;
    logic                                input_start_q;
    logic                                busy_q;
    logic                                done_q;
    logic                                go_err_q;
    logic [2*N-1:0]                      mask_q;
    logic [N*DATA_W-1:0]                 in_a_q;
    logic [N*DATA_W-1:0]                 in_b_q;
    logic [N-1:0][N-1:0][DATA_W-1:0]     mat_a_q;
    logic [N-1:0][N-1:0][DATA_W-1:0]     mat_b_q;

    logic [CNT_W-1:0]                    next_beat_d;
    logic [N*DATA_W-1:0]                 lane_a;
    logic [N*DATA_W-1:0]                 lane_b;
    logic                                load_accept;

    assign load_accept = bus.load_valid && (state_q == IDLE);

    // The data registered alongside counter value c must be beat c, so the
    // skew is evaluated for the value the counter is about to take.
    assign next_beat_d = counter_q + 4'd1;

    skew_select #(.DATA_W(DATA_W)) u_skew (
        .beat_i   (next_beat_d),
        .mat_a_i  (mat_a_q),
        .mat_b_i  (mat_b_q),
        .lane_a_o (lane_a),
        .lane_b_o (lane_b)
    );

    // Matrix row storage, written only by accepted loads.
    // NOTE: the matrices carry no reset; the mask guards them, and leaving them
    // out of reset keeps them plain storage instead of a wide reset fan-out.
    always_ff @(posedge clk) begin
        if (!rst && load_accept) begin
            for (int j = 0; j < N; j++) begin
                if (bus.load_sel) begin
                    mat_b_q[bus.load_row][j] <= bus.load_data[(N-1-j)*DATA_W +: DATA_W];
                end else begin
                    mat_a_q[bus.load_row][j] <= bus.load_data[(N-1-j)*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Control FSM with registered outputs; the mask is updated here so go sees its pre-load value.
    // NOTE: non-blocking assignments throughout, so every test of mask_q or
    // counter_q in this block reads the value from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            start_cnt_q   <= 1'b0;
            input_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            go_err_q      <= 1'b0;
            mask_q        <= '0;
            in_a_q        <= '0;
            in_b_q        <= '0;
        end else begin
            done_q   <= 1'b0;
            go_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        if (&mask_q) begin
                            state_q       <= START;
                            start_cnt_q   <= 1'b0;
                            input_start_q <= 1'b1;
                            busy_q        <= 1'b1;
                        end else begin
                            go_err_q <= 1'b1;
                        end
                    end
                    if (load_accept) begin
                        mask_q[mask_idx(bus.load_sel, bus.load_row)] <= 1'b1;
                    end
                end
                START: begin
                    if (start_cnt_q) begin
                        state_q       <= STREAM;
                        input_start_q <= 1'b0;
                        counter_q     <= next_beat_d;
                        in_a_q        <= lane_a;
                        in_b_q        <= lane_b;
                    end else begin
                        start_cnt_q <= 1'b1;
                    end
                end
                STREAM: begin
                    counter_q <= next_beat_d;
                    if (counter_q == STREAM_LAST) begin
                        state_q <= FLUSH;
                        in_a_q  <= '0;
                        in_b_q  <= '0;
                    end else begin
                        in_a_q <= lane_a;
                        in_b_q <= lane_b;
                    end
                end
                FLUSH: begin
                    if (counter_q == FLUSH_LAST) begin
                        state_q   <= IDLE;
                        counter_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        counter_q <= next_beat_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_ready  = (state_q == IDLE);
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.go_err      = go_err_q;
    assign bus.input_start = input_start_q;
    assign bus.counter     = counter_q;
    assign bus.inA_flat    = in_a_q;
    assign bus.inB_flat    = in_b_q;

endmodule
